alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one ALU datapath between two requesters (e.g. pipe0/pipe1 issue ports).
//  Round-robin arbitration, one op accepted per cycle, result held in a
//  one-entry output register under valid/ready backpressure.
//  Sits between the issue logic and writeback; owns the only ALU instance.
// PARAMETERS
//  XLEN   32  operand/result width; shift amount uses rs2[$clog2(XLEN)-1:0]
//  TAG_W  4   width of requester-supplied tag echoed with the result
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  req0_valid  in   1      requester 0 has an op
//  req0_ready  out  1      requester 0 op accepted this cycle (valid&ready)
//  req0_op     in   4      op code {funct7[5],funct3}, see BEHAVIOUR
//  req0_rs1    in   XLEN   operand 1
//  req0_rs2    in   XLEN   operand 2
//  req0_tag    in   TAG_W  opaque tag
//  req1_*      --   --     identical set for requester 1
//  rsp_valid   out  1      result register holds a result
//  rsp_ready   in   1      consumer takes result (valid&ready)
//  rsp_data    out  XLEN   result
//  rsp_src     out  1      requester that issued the op (0/1)
//  rsp_tag     out  TAG_W  echoed tag
//  rsp_err     out  1      op code illegal; rsp_data forced to 0
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_data=0, rsp_src=0, rsp_tag=0, rsp_err=0, last=1
//   (so req0 wins first contention). reqN_ready combinational, 0 while rst_n=0.
//  Ops: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU,
//   0100 XOR, 0101 SRL, 1101 SRA (arith), 0110 OR, 0111 AND; others illegal.
//   Add/sub wrap modulo 2^XLEN; SLT/SLTU give 1 or 0 zero-extended.
//  can_accept = !rsp_valid | rsp_ready (output reg empty or draining this cycle).
//  Grant: only req0 valid -> 0; only req1 valid -> 1; both -> !last.
//   reqN_ready = can_accept & grant==N & reqN_valid; at most one ready high.
//  On accept: rsp_* loaded next edge, rsp_valid=1, last<=grant. Latency 1 cycle
//   (accept edge N -> rsp_valid at cycle N+1). Back-to-back accepts allowed
//   when rsp_ready=1 (throughput 1 op/cycle, no bubble).
//  Drain without accept: rsp_valid<=0; rsp_data/src/tag/err hold last value.
//  Stall: rsp_valid&!rsp_ready -> both ready=0; rsp_* stable until taken.
//  last updates only on an accept; idle cycles do not move the pointer.
//  Requester rule: once valid, op/rs1/rs2/tag stable until ready (not checked).
//  Illegal op: accepted normally, rsp_err=1, rsp_data=0.
//  Reset mid-operation: pending result discarded, rsp_valid=0 immediately
//   (async), no ready asserted until rst_n deasserts.
// TESTING
//  1. req0 ADD 0xFFFF_FFFF+0x1, rsp_ready=1 -> next cycle rsp_valid=1,
//     rsp_data=0, rsp_src=0, rsp_err=0.
//  2. req0 and req1 valid continuously, rsp_ready=1 -> grants 0,1,0,1...,
//     one rsp per cycle, tags in issue order, no bubbles.
//  3. req1 SRA rs1=0x8000_0000 rs2=0x24 with rsp_ready=0 for 3 cycles ->
//     rsp_data=0xF800_0000 held stable, req*_ready=0 while stalled.
//  4. SLT 0xFFFF_FFFF,1 -> 1; SLTU same operands -> 0; SUB 0,1 -> 0xFFFF_FFFF.
//  5. op=1111 -> rsp_err=1, rsp_data=0; next legal op clears rsp_err.
//  6. Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 same cycle; after
//     release, both valid -> req0 granted first.

Source files
------------

// File: rtl/alu_share_if.sv
// Request/response bundle between the two issue ports, the shared ALU arbiter and writeback.
// Master drives requests and rsp_ready; slave (the arbiter) drives grants and results.
interface alu_share_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [XLEN-1:0]  req0_rs1;
  logic [XLEN-1:0]  req0_rs2;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [XLEN-1:0]  req1_rs1;
  logic [XLEN-1:0]  req1_rs2;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_rs1, req0_rs2, req0_tag,
    input  req0_ready,
    output req1_valid, req1_op, req1_rs1, req1_rs2, req1_tag,
    input  req1_ready,
    output rsp_ready,
    input  rsp_valid, rsp_data, rsp_src, rsp_tag, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_rs1, req0_rs2, req0_tag,
    output req0_ready,
    input  req1_valid, req1_op, req1_rs1, req1_rs2, req1_tag,
    output req1_ready,
    input  rsp_ready,
    output rsp_valid, rsp_data, rsp_src, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two issue ports, with a
// one-entry result register under valid/ready backpressure.
module alu_share_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_share_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  logic             last;
  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [3:0]       sel_op;
  logic [XLEN-1:0]  sel_rs1;
  logic [XLEN-1:0]  sel_rs2;
  logic [TAG_W-1:0] sel_tag;
  logic [SH_W-1:0]  shamt;
  logic [XLEN-1:0]  alu_res;
  logic             alu_err;

  assign can_accept = !bus.rsp_valid || bus.rsp_ready;

  // Contention goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = !last;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign bus.req0_ready = rst_n && can_accept && bus.req0_valid && !grant;
  assign bus.req1_ready = rst_n && can_accept && bus.req1_valid &&  grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  always_comb begin
    sel_op  = bus.req0_op;
    sel_rs1 = bus.req0_rs1;
    sel_rs2 = bus.req0_rs2;
    sel_tag = bus.req0_tag;
    if (grant) begin
      sel_op  = bus.req1_op;
      sel_rs1 = bus.req1_rs1;
      sel_rs2 = bus.req1_rs2;
      sel_tag = bus.req1_tag;
    end
  end

  assign shamt = sel_rs2[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (sel_op)
      OP_ADD:  alu_res = sel_rs1 + sel_rs2;
      OP_SUB:  alu_res = sel_rs1 - sel_rs2;
      OP_SLL:  alu_res = sel_rs1 << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(sel_rs1) < $signed(sel_rs2))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (sel_rs1 < sel_rs2)};
      OP_XOR:  alu_res = sel_rs1 ^ sel_rs2;
      OP_SRL:  alu_res = sel_rs1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(sel_rs1) >>> shamt);
      OP_OR:   alu_res = sel_rs1 | sel_rs2;
      OP_AND:  alu_res = sel_rs1 & sel_rs2;
      default: alu_err = 1'b1;
    endcase
  end

  // Payload fields hold their value on drain so writeback sees a stable bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_src   <= 1'b0;
      bus.rsp_tag   <= '0;
      bus.rsp_err   <= 1'b0;
      last          <= 1'b1;
    end else if (accept) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_data  <= alu_res;
      bus.rsp_src   <= grant;
      bus.rsp_tag   <= sel_tag;
      bus.rsp_err   <= alu_err;
      last          <= grant;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end
endmodule
